// File: rtl/rf_pkg.sv
// Shared types and sizing for the register-file write scheduler.
// Source numbering fixes arbitration order and the grant_src encoding.
package rf_pkg;

   localparam int NUM_SRC  = 4;
   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_DMEM = 2'd1,
      SRC_IMM  = 2'd2,
      SRC_IMEM = 2'd3
   } src_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Request bus from the four write sources plus the register-file write port
// and hazard outputs that the scheduler drives.
interface rf_write_arbiter_if #(
   parameter int NUM_SRC = rf_pkg::NUM_SRC,
   parameter int DATA_W  = rf_pkg::DATA_W,
   parameter int ADDR_W  = rf_pkg::ADDR_W
);
   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [NUM_SRC-1:0]        req_valid;
   logic [NUM_SRC-1:0]        req_ready;
   logic [NUM_SRC*ADDR_W-1:0] req_addr;
   logic [NUM_SRC*DATA_W-1:0] req_data;
   logic                      rf_we;
   logic [ADDR_W-1:0]         rf_waddr;
   logic [DATA_W-1:0]         rf_wdata;
   logic [1:0]                grant_src;
   logic [NUM_REGS-1:0]       pending_mask;
   logic                      r0_drop;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, rf_we, rf_waddr, rf_wdata, grant_src, pending_mask, r0_drop
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, rf_we, rf_waddr, rf_wdata, grant_src, pending_mask, r0_drop
   );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter4.sv
// Four-way round-robin picker: the first requester at or after ptr (mod 4) wins.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       any_grant
);

   logic [1:0] idx;

   always_comb begin
      grant     = 4'b0000;
      grant_idx = 2'd0;
      any_grant = 1'b0;
      idx       = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!any_grant && req[idx]) begin
            any_grant = 1'b1;
            grant_idx = idx;
         end
      end
      if (any_grant) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-port scheduler: one-entry buffer per source, round-robin grant into a
// registered write port, and a per-register pending mask for decode stalls.
module rf_write_arbiter #(
   parameter int NUM_SRC = rf_pkg::NUM_SRC,
   parameter int DATA_W  = rf_pkg::DATA_W,
   parameter int ADDR_W  = rf_pkg::ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   rf_write_arbiter_if.slave   bus
);
   import rf_pkg::*;

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [NUM_SRC-1:0] full_reg;
   wr_req_t            buf_reg [NUM_SRC];
   logic [1:0]         rr_ptr_reg;

   logic               rf_we_reg;
   logic [ADDR_W-1:0]  rf_waddr_reg;
   logic [DATA_W-1:0]  rf_wdata_reg;
   src_e               grant_src_reg;
   logic               r0_drop_reg;

   logic [3:0]         grant_oh;
   logic [1:0]         grant_idx;
   logic               any_grant;

   logic [ADDR_W-1:0]  src_addr [NUM_SRC];
   logic [NUM_SRC-1:0] is_r0;
   logic [NUM_SRC-1:0] ready;
   logic [NUM_SRC-1:0] accept;

   rr_arbiter4 u_arb (
      .req       (full_reg),
      .ptr       (rr_ptr_reg),
      .grant     (grant_oh),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic blocked;

         assign src_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
         assign is_r0[gi]    = (src_addr[gi] == '0);

         // A buffer leaving this cycle no longer holds the register. A lower-indexed
         // source asking for the same register this cycle wins, so only one of them
         // can be in flight.
         always_comb begin
            blocked = 1'b0;
            for (int t = 0; t < NUM_SRC; t++) begin
               if (t != gi) begin
                  if (full_reg[t] && !grant_oh[t] && (buf_reg[t].addr == src_addr[gi])) begin
                     blocked = 1'b1;
                  end
                  if ((t < gi) && bus.req_valid[t] && (src_addr[t] == src_addr[gi])) begin
                     blocked = 1'b1;
                  end
               end
            end
         end

         assign ready[gi]  = is_r0[gi] | ((~full_reg[gi] | grant_oh[gi]) & ~blocked);
         assign accept[gi] = bus.req_valid[gi] & ready[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         full_reg <= '0;
         for (int s = 0; s < NUM_SRC; s++) begin
            buf_reg[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (accept[s] && !is_r0[s]) begin
               full_reg[s] <= 1'b1;
               buf_reg[s]  <= '{addr: src_addr[s], data: bus.req_data[s*DATA_W +: DATA_W]};
            end else if (grant_oh[s]) begin
               full_reg[s] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_reg    <= 2'd0;
         rf_we_reg     <= 1'b0;
         rf_waddr_reg  <= '0;
         rf_wdata_reg  <= '0;
         grant_src_reg <= SRC_ALU;
         r0_drop_reg   <= 1'b0;
      end else begin
         rf_we_reg   <= any_grant;
         r0_drop_reg <= |(accept & is_r0);
         if (any_grant) begin
            rr_ptr_reg    <= grant_idx + 2'd1;
            rf_waddr_reg  <= buf_reg[grant_idx].addr;
            rf_wdata_reg  <= buf_reg[grant_idx].data;
            grant_src_reg <= src_e'(grant_idx);
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
         logic hit;

         always_comb begin
            hit = rf_we_reg && (rf_waddr_reg == ADDR_W'(gi));
            for (int s = 0; s < NUM_SRC; s++) begin
               if (full_reg[s] && (buf_reg[s].addr == ADDR_W'(gi))) begin
                  hit = 1'b1;
               end
            end
         end

         assign bus.pending_mask[gi] = hit;
      end
   endgenerate

   assign bus.req_ready = ready;
   assign bus.rf_we     = rf_we_reg;
   assign bus.rf_waddr  = rf_waddr_reg;
   assign bus.rf_wdata  = rf_wdata_reg;
   assign bus.grant_src = grant_src_reg;
   assign bus.r0_drop   = r0_drop_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: hand-computed expectations for latency,
// round-robin order, same-register hazards, r0 discard and mid-flight reset.
module tb_rf_write_arbiter;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   rf_write_arbiter_if bus ();

   rf_write_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input logic v, input logic [2:0] a, input logic [31:0] d);
      bus.req_valid[s]        = v;
      bus.req_addr[s*3 +: 3]  = a;
      bus.req_data[s*32 +: 32] = d;
   endtask

   task automatic clear_all();
      for (int s = 0; s < 4; s++) begin
         set_src(s, 1'b0, 3'd0, 32'd0);
      end
   endtask

   // Fire all four sources in one cycle and check the expected grant order.
   task automatic burst4(input logic [1:0] first, input string tag);
      logic [2:0] addr_of [4];
      logic [1:0] src;
      addr_of[0] = 3'd1;
      addr_of[1] = 3'd2;
      addr_of[2] = 3'd4;
      addr_of[3] = 3'd5;
      for (int s = 0; s < 4; s++) begin
         set_src(s, 1'b1, addr_of[s], 32'h100 + 32'(s));
      end
      step();
      clear_all();
      check({tag, ".pend"}, 64'(bus.pending_mask), 64'h36);
      for (int i = 0; i < 4; i++) begin
         src = first + 2'(i);
         step();
         check($sformatf("%s.we%0d", tag, i), 64'(bus.rf_we), 64'd1);
         check($sformatf("%s.src%0d", tag, i), 64'(bus.grant_src), 64'(src));
         check($sformatf("%s.addr%0d", tag, i), 64'(bus.rf_waddr), 64'(addr_of[src]));
         check($sformatf("%s.data%0d", tag, i), 64'(bus.rf_wdata), 64'h100 + 64'(src));
      end
      step();
      check({tag, ".idle"}, 64'(bus.rf_we), 64'd0);
   endtask

   task automatic single(input int s, input logic [2:0] a, input logic [31:0] d);
      set_src(s, 1'b1, a, d);
      step();
      clear_all();
      step();
      check($sformatf("single%0d.src", s), 64'(bus.grant_src), 64'(s));
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      step();
      step();

      check("rst.we", 64'(bus.rf_we), 64'd0);
      check("rst.waddr", 64'(bus.rf_waddr), 64'd0);
      check("rst.wdata", 64'(bus.rf_wdata), 64'd0);
      check("rst.src", 64'(bus.grant_src), 64'd0);
      check("rst.r0drop", 64'(bus.r0_drop), 64'd0);
      check("rst.pend", 64'(bus.pending_mask), 64'd0);
      check("rst.ready", 64'(bus.req_ready), 64'hf);
      rst = 1'b1;
      step();

      // Single ALU write: accept, grant, then visible on the write port.
      set_src(0, 1'b1, 3'd3, 32'hDEADBEEF);
      step();
      clear_all();
      check("alu.we0", 64'(bus.rf_we), 64'd0);
      check("alu.pend0", 64'(bus.pending_mask), 64'h08);
      step();
      check("alu.we1", 64'(bus.rf_we), 64'd1);
      check("alu.waddr", 64'(bus.rf_waddr), 64'd3);
      check("alu.wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
      check("alu.src", 64'(bus.grant_src), 64'd0);
      check("alu.pend1", 64'(bus.pending_mask), 64'h08);
      step();
      check("alu.we2", 64'(bus.rf_we), 64'd0);
      check("alu.pend2", 64'(bus.pending_mask), 64'h00);
      check("alu.hold", 64'(bus.rf_waddr), 64'd3);

      // rr_ptr is 1 here; an IMEM write brings it back to 0.
      single(3, 3'd7, 32'h77);
      burst4(2'd0, "rr0");
      // A DMEM write moves the pointer to 2.
      single(1, 3'd2, 32'hAA);
      burst4(2'd2, "rr2");

      // Hazard on r6: pointer is 2, so grants go IMEM, ALU, DMEM, then IMM.
      set_src(0, 1'b1, 3'd1, 32'h10);
      set_src(1, 1'b1, 3'd6, 32'hA6);
      set_src(3, 1'b1, 3'd7, 32'h37);
      step();
      clear_all();
      set_src(2, 1'b1, 3'd6, 32'hB6);
      #1;
      check("haz.rdy_a", 64'(bus.req_ready[2]), 64'd0);
      step();
      check("haz.src_a", 64'(bus.grant_src), 64'd3);
      check("haz.rdy_b", 64'(bus.req_ready[2]), 64'd0);
      step();
      check("haz.src_b", 64'(bus.grant_src), 64'd0);
      check("haz.rdy_c", 64'(bus.req_ready[2]), 64'd1);
      step();
      clear_all();
      check("haz.src_c", 64'(bus.grant_src), 64'd1);
      check("haz.addr_c", 64'(bus.rf_waddr), 64'd6);
      check("haz.data_c", 64'(bus.rf_wdata), 64'hA6);
      step();
      check("haz.src_d", 64'(bus.grant_src), 64'd2);
      check("haz.addr_d", 64'(bus.rf_waddr), 64'd6);
      check("haz.data_d", 64'(bus.rf_wdata), 64'hB6);
      step();
      check("haz.idle", 64'(bus.rf_we), 64'd0);

      // Register 0 request is accepted and dropped.
      set_src(2, 1'b1, 3'd0, 32'h55);
      #1;
      check("r0.ready", 64'(bus.req_ready[2]), 64'd1);
      step();
      clear_all();
      check("r0.drop", 64'(bus.r0_drop), 64'd1);
      check("r0.we", 64'(bus.rf_we), 64'd0);
      check("r0.pend", 64'(bus.pending_mask), 64'd0);
      step();
      check("r0.drop_end", 64'(bus.r0_drop), 64'd0);
      check("r0.we_end", 64'(bus.rf_we), 64'd0);

      // Reset while three buffers are full and a write is on the port.
      for (int s = 0; s < 4; s++) begin
         set_src(s, 1'b1, 3'(s + 1), 32'hC0 + 32'(s));
      end
      step();
      clear_all();
      step();
      check("mid.we", 64'(bus.rf_we), 64'd1);
      check("mid.src", 64'(bus.grant_src), 64'd3);
      check("mid.pend", 64'(bus.pending_mask), 64'h1E);
      rst = 1'b0;
      step();
      check("mid.rst_we", 64'(bus.rf_we), 64'd0);
      check("mid.rst_rdy", 64'(bus.req_ready), 64'hf);
      check("mid.rst_pend", 64'(bus.pending_mask), 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("mid.after%0d", i), 64'(bus.rf_we), 64'd0);
      end

      // ALU streams r1..r7 back to back.
      for (int k = 1; k <= 9; k++) begin
         if (k <= 7) begin
            set_src(0, 1'b1, 3'(k), 32'h1000 + 32'(k));
            #1;
            check($sformatf("strm.rdy%0d", k), 64'(bus.req_ready[0]), 64'd1);
         end else begin
            clear_all();
         end
         step();
         check($sformatf("strm.we%0d", k), 64'(bus.rf_we), ((k >= 2) && (k <= 8)) ? 64'd1 : 64'd0);
         if ((k >= 2) && (k <= 8)) begin
            check($sformatf("strm.addr%0d", k), 64'(bus.rf_waddr), 64'(k - 1));
            check($sformatf("strm.data%0d", k), 64'(bus.rf_wdata), 64'h1000 + 64'(k - 1));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
